// File: rtl/store_buffer.sv
// Store buffer: in-order circular FIFO of {addr, data} stores draining to memory.
// Ports: clk, rst_n; cpu_addr/cpu_data/cpu_write in; full/empty/count/overflow
// status out; mem_addr/mem_data/mem_valid out with mem_ready in.
// Optional: define STORE_BUFFER_MERGE_EN to merge stores into the newest entry.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                cpu_addr,
  input  logic [31:0]                cpu_data,
  input  logic                       cpu_write,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_data,
  output logic                       mem_valid,
  input  logic                       mem_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];

  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_merge;
  logic w_nonempty;

  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty & mem_ready;

`ifdef STORE_BUFFER_MERGE_EN
  logic [PW-1:0] w_newest;
  assign w_newest = r_tail - PW'(1);
  // count >= 2 keeps the head (possibly mid-retire) out of reach.
  assign w_merge  = cpu_write & (r_count >= CW'(2))
                  & (cpu_addr == r_addr[w_newest]);
`else
  assign w_merge  = 1'b0;
`endif

  assign w_push = cpu_write & ((r_count != DEPTH_C) | w_pop) & ~w_merge;
  assign w_drop = cpu_write & (r_count == DEPTH_C) & ~w_pop & ~w_merge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_push) r_tail <= r_tail + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= cpu_addr;
      r_data[r_tail] <= cpu_data;
    end
`ifdef STORE_BUFFER_MERGE_EN
    if (w_merge) r_data[w_newest] <= cpu_data;
`endif
  end

  assign count     = r_count;
  assign full      = (r_count == DEPTH_C);
  assign empty     = ~w_nonempty;
  assign overflow  = r_ovf;
  assign mem_valid = w_nonempty;
  assign mem_addr  = w_nonempty ? r_addr[r_head] : 32'h0;
  assign mem_data  = w_nonempty ? r_data[r_head] : 32'h0;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: queue reference model predicts
// accepted stores; a negedge monitor checks every retired entry.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_data;
  logic          cpu_write;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_data;
  logic          mem_valid;
  logic          mem_ready;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_write(cpu_write),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t mdl[$];
  ent_t exp_q[$];
  bit   ovf_m;
  int   rst_gen = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: a queue with capacity DEPTH, applied per clock edge.
  task automatic model(input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit rdy);
    int   sb;
    bit   pop;
    bit   mrg;
    ent_t e;
    sb  = mdl.size();
    pop = rdy && sb > 0;
    mrg = 1'b0;
`ifdef STORE_BUFFER_MERGE_EN
    if (w && sb >= 2 && mdl[sb-1].a == a) mrg = 1'b1;
`endif
    if (pop) void'(mdl.pop_front());
    if (mrg) begin
      e = mdl.pop_back();   e.d = d; mdl.push_back(e);
      e = exp_q.pop_back(); e.d = d; exp_q.push_back(e);
    end else if (w && (sb < DEPTH || pop)) begin
      e.a = a; e.d = d;
      mdl.push_back(e);
      exp_q.push_back(e);
    end else if (w) begin
      ovf_m = 1'b1;
    end
  endtask

  task automatic step(input bit w, input logic [31:0] a,
                      input logic [31:0] d, input bit rdy);
    cpu_write = w; cpu_addr = a; cpu_data = d; mem_ready = rdy;
    model(w, a, d, rdy);
    @(posedge clk); #1;
    chk("count", 32'(count), 32'(mdl.size()));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("full", 32'(full), 32'(mdl.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mdl.size() == 0));
    chk("mem_valid", 32'(mem_valid), 32'(mdl.size() != 0));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
  endtask

  // Asynchronous pulse between clock edges.
  task automatic rst_pulse();
    cpu_write = 1'b0; mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_mem_valid", 32'(mem_valid), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    #1 rst_n = 1'b1;
    mdl.delete();
    exp_q.delete();
    ovf_m = 1'b0;
    rst_gen++;
    @(posedge clk); #1;
  endtask

  // Monitor: retires scoreboard entries and checks hold stability.
  initial begin : monitor
    bit          p_hold;
    logic [31:0] p_a;
    logic [31:0] p_d;
    int          p_gen;
    ent_t        e;
    p_hold = 1'b0; p_a = '0; p_d = '0; p_gen = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (p_hold && mem_valid && p_gen == rst_gen) begin
          chk("hold_addr_stable", mem_addr, p_a);
          chk("hold_data_stable", mem_data, p_d);
        end
        if (mem_valid && mem_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pop_addr", mem_addr, 32'hxxxxxxxx);
          end else begin
            e = exp_q.pop_front();
            chk("drain_addr", mem_addr, e.a);
            chk("drain_data", mem_data, e.d);
          end
        end
        p_hold = mem_valid && !mem_ready;
        p_a = mem_addr; p_d = mem_data; p_gen = rst_gen;
      end
    end
  end

  initial begin
    rst_n = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_data = '0;
    mem_ready = 1'b0; ovf_m = 1'b0;
    #12;
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_empty", 32'(empty), 32'h1);
    chk("reset_full", 32'(full), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);
    chk("reset_mem_valid", 32'(mem_valid), 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ready while empty must not underflow
    step(1'b0, 32'h0, 32'h0, 1'b1);

    // single store, one-cycle latency, pops next cycle
    step(1'b1, 32'h100, 32'hAA, 1'b1);
    chk("single_addr", mem_addr, 32'h100);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("single_empty", 32'(empty), 32'h1);

    // overflow: 5 stores into depth 4, last one lost
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'(i * 4), 32'(32'hD0 + i), 1'b0);
    chk("ovf_full", 32'(full), 32'h1);
    chk("ovf_flag", 32'(overflow), 32'h1);
    drain(6);

    // full plus simultaneous pop accepts the store
    rst_pulse();
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(32'h200 + i * 4), 32'(i), 1'b0);
    step(1'b1, 32'h280, 32'h55, 1'b1);
    chk("fullpop_count", 32'(count), 32'h4);
    chk("fullpop_ovf", 32'(overflow), 32'h0);
    drain(6);

    // head held three cycles
    step(1'b1, 32'h300, 32'h33, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0);
      chk("stall_addr", mem_addr, 32'h300);
      chk("stall_data", mem_data, 32'h33);
    end
    drain(3);

    // reset mid-drain with three entries
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(32'h400 + i * 4), 32'(i), 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("pre_rst_count", 32'(count), 32'h3);
    rst_pulse();
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("post_rst_no_replay", 32'(mem_valid), 32'h0);

`ifdef STORE_BUFFER_MERGE_EN
    step(1'b1, 32'h20, 32'h1, 1'b0);
    step(1'b1, 32'h24, 32'h2, 1'b0);
    step(1'b1, 32'h24, 32'h3, 1'b0);
    chk("merge_count", 32'(count), 32'h2);
    drain(4);
`endif

    // randomized traffic, small address set to exercise merging
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)) << 2,
           $urandom, 1'($urandom_range(0, 1)));
    drain(DEPTH + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
